// File: rtl/token_rr_scheduler.sv
// Round-robin burst scheduler: shares one downstream token port between N_IN
// upstream streams, holding each grant for BURST_LEN tokens so bursts stay
// contiguous, and forwards tokens through a one-entry output register.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no grant; pick next requester after ptr, load burst length
// S_BURST | stream g granted; accept tokens until rem reaches zero
module token_rr_scheduler #(
    parameter int N_IN   = 3,
    parameter int DATA_W = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [15:0]              BURST_LEN,
    input  logic [N_IN-1:0]          In_SEND,
    input  logic [N_IN*DATA_W-1:0]   In_DATA,
    input  logic [N_IN*16-1:0]       In_COUNT,
    output logic [N_IN-1:0]          In_ACK,
    output logic                     Out_SEND,
    output logic [DATA_W-1:0]        Out_DATA,
    output logic [15:0]              Out_COUNT,
    input  logic                     Out_RDY,
    input  logic                     Out_ACK,
    output logic [N_IN-1:0]          GRANT,
    output logic                     BUSY
);

    localparam int IDX_W = $clog2(N_IN);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   g_q, g_d;
    logic [15:0]        rem_q, rem_d;
    logic [DATA_W-1:0]  obuf_data_q, obuf_data_d;
    logic               obuf_valid_q, obuf_valid_d;

    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic [DATA_W-1:0]  g_data;
    logic               g_send;
    logic               space;
    logic               accept;

    // Debug-only taps; intentionally not part of any datapath.
    logic               unused_taps;
    assign unused_taps = ^{In_COUNT, Out_ACK};

    // Next requester after ptr with wrap: indices above ptr first, then the rest.
    always_comb begin
        sel_idx   = ptr_q;
        sel_found = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (!sel_found && In_SEND[i] && (IDX_W'(i) > ptr_q)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_IN; i++) begin
            if (!sel_found && In_SEND[i] && (IDX_W'(i) <= ptr_q)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Mux the granted stream's request and data.
    always_comb begin
        g_data = '0;
        g_send = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (IDX_W'(i) == g_q) begin
                g_data = In_DATA[i*DATA_W +: DATA_W];
                g_send = In_SEND[i];
            end
        end
    end

    // FSM next state, acknowledge generation and output register update.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        g_d          = g_q;
        rem_d        = rem_q;
        obuf_data_d  = obuf_data_q;
        obuf_valid_d = obuf_valid_q;
        In_ACK       = '0;
        accept       = 1'b0;

        Out_SEND  = obuf_valid_q & Out_RDY;
        space     = ~obuf_valid_q | Out_SEND;

        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    g_d     = sel_idx;
                    ptr_d   = sel_idx;
                    rem_d   = (BURST_LEN == 16'd0) ? 16'd1 : BURST_LEN;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                accept = g_send & space;
                for (int i = 0; i < N_IN; i++) begin
                    if (IDX_W'(i) == g_q) begin
                        In_ACK[i] = accept;
                    end
                end
                if (accept) begin
                    if (rem_q != 16'd0) begin
                        rem_d = rem_q - 16'd1;
                    end
                    if (rem_q <= 16'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A drain and an accept in the same cycle keep the register full.
        if (accept) begin
            obuf_data_d  = g_data;
            obuf_valid_d = 1'b1;
        end else if (Out_SEND) begin
            obuf_valid_d = 1'b0;
        end
    end

    // State and output register; reset discards any buffered token.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            ptr_q        <= IDX_W'(N_IN - 1);
            g_q          <= '0;
            rem_q        <= '0;
            obuf_data_q  <= '0;
            obuf_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            g_q          <= g_d;
            rem_q        <= rem_d;
            obuf_data_q  <= obuf_data_d;
            obuf_valid_q <= obuf_valid_d;
        end
    end

    // Status and output-side decode.
    always_comb begin
        Out_DATA  = obuf_data_q;
        Out_COUNT = Out_SEND ? 16'h0001 : 16'h0000;
        GRANT     = (state_q == S_BURST) ? ({{(N_IN-1){1'b0}}, 1'b1} << g_q) : '0;
        BUSY      = (state_q == S_BURST) | obuf_valid_q;
    end

endmodule

// File: tb/tb_token_rr_scheduler.sv
// Scoreboard bench for token_rr_scheduler: the bench predicts the output
// token order per scenario, pushes it to a queue, and pops it on Out_SEND.
module tb_token_rr_scheduler;

    localparam int N = 3;
    localparam int W = 16;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [15:0]      BURST_LEN;
    logic [N-1:0]     In_SEND;
    logic [N*W-1:0]   In_DATA;
    logic [N*16-1:0]  In_COUNT;
    logic [N-1:0]     In_ACK;
    logic             Out_SEND;
    logic [W-1:0]     Out_DATA;
    logic [15:0]      Out_COUNT;
    logic             Out_RDY;
    logic             out_ack;
    logic [N-1:0]     GRANT;
    logic             BUSY;

    assign out_ack = Out_SEND;

    token_rr_scheduler #(.N_IN(N), .DATA_W(W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .BURST_LEN (BURST_LEN),
        .In_SEND   (In_SEND),
        .In_DATA   (In_DATA),
        .In_COUNT  (In_COUNT),
        .In_ACK    (In_ACK),
        .Out_SEND  (Out_SEND),
        .Out_DATA  (Out_DATA),
        .Out_COUNT (Out_COUNT),
        .Out_RDY   (Out_RDY),
        .Out_ACK   (out_ack),
        .GRANT     (GRANT),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [15:0] src_next[N];
    int          src_cnt[N];
    logic        src_en[N];

    logic [N-1:0] grant_s, ack_s;
    logic         send_s, busy_s;
    logic [W-1:0] data_s;
    logic [15:0]  cnt_s;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            In_SEND[i]            = src_en[i] && (src_cnt[i] > 0);
            In_DATA[i*W +: W]     = src_next[i];
            In_COUNT[i*16 +: 16]  = 16'(src_cnt[i]);
        end
    endtask

    task automatic load(input int i, input logic [15:0] start, input int n);
        src_next[i] = start;
        src_cnt[i]  = n;
        src_en[i]   = 1'b1;
        drive();
    endtask

    task automatic push(input logic [15:0] d);
        exp_q.push_back(d);
    endtask

    // One cycle: sample outputs mid-cycle, score output tokens, then retire
    // acknowledged source tokens after the edge.
    task automatic tick();
        logic [15:0] e;
        @(negedge CLK);
        grant_s = GRANT;
        ack_s   = In_ACK;
        send_s  = Out_SEND;
        busy_s  = BUSY;
        data_s  = Out_DATA;
        cnt_s   = Out_COUNT;
        check("ack_in_grant", 32'(ack_s & ~grant_s), 0);
        if (send_s) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", data_s, e);
                check("out_count", cnt_s, 16'h1);
            end
        end else begin
            check("count_idle", cnt_s, 0);
        end
        @(posedge CLK);
        #1;
        for (int i = 0; i < N; i++) begin
            if (ack_s[i]) begin
                src_next[i] = src_next[i] + 16'd1;
                src_cnt[i]  = src_cnt[i] - 1;
            end
        end
        drive();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        tick();
        while ((exp_q.size() != 0 || busy_s) && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_drain_q"}, exp_q.size(), 0);
        check({tag, "_drain_busy"}, 32'(busy_s), 0);
    endtask

    task automatic reset_dut();
        RESET = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_cnt[i] = 0;
            src_en[i]  = 1'b0;
        end
        drive();
        tick();
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        RESET     = 1'b1;
        BURST_LEN = 16'd4;
        Out_RDY   = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_next[i] = '0;
            src_cnt[i]  = 0;
            src_en[i]   = 1'b0;
        end
        drive();
        repeat (2) @(posedge CLK);
        #1;
        tick();
        check("rst_grant", grant_s, 0);
        check("rst_ack", ack_s, 0);
        check("rst_send", 32'(send_s), 0);
        check("rst_busy", 32'(busy_s), 0);
        check("rst_data", data_s, 0);
        check("rst_count", cnt_s, 0);
        RESET = 1'b0;

        // Single stream, burst of 4.
        BURST_LEN = 16'd4;
        load(0, 16'd10, 4);
        for (int k = 0; k < 4; k++) push(16'(10 + k));
        tick();
        check("t1_grant_c0", grant_s, 0);
        tick();
        check("t1_grant_c1", grant_s, 3'b001);
        check("t1_ack_c1", ack_s, 3'b001);
        for (int k = 2; k <= 5; k++) begin
            tick();
            check("t1_send", 32'(send_s), 1);
            check("t1_grant", grant_s, (k <= 4) ? 3'b001 : 3'b000);
        end
        drain("t1");

        // Round-robin fairness, all streams requesting, burst of 2.
        reset_dut();
        BURST_LEN = 16'd2;
        for (int s = 0; s < N; s++) load(s, 16'(s << 8), 4);
        for (int j = 0; j < 6; j++)
            for (int b = 0; b < 2; b++)
                push(16'(((j % 3) << 8) + 2 * (j / 3) + b));
        tick();
        check("t2_grant_c0", grant_s, 0);
        for (int k = 1; k <= 18; k++) begin
            tick();
            check("t2_grant", grant_s,
                  (((k - 1) % 3) < 2) ? 3'(1 << (((k - 1) / 3) % 3)) : 3'b000);
            check("t2_send", 32'(send_s), (k >= 2 && ((k - 2) % 3) != 2) ? 1 : 0);
        end
        drain("t2");

        // Backpressure: Out_RDY low for 5 cycles mid-burst.
        reset_dut();
        BURST_LEN = 16'd6;
        load(0, 16'h300, 6);
        for (int k = 0; k < 6; k++) push(16'(16'h300 + k));
        tick();
        tick();
        tick();
        Out_RDY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_stall_ack", ack_s, 0);
            check("t3_stall_send", 32'(send_s), 0);
            check("t3_stall_busy", 32'(busy_s), 1);
            check("t3_stall_data", data_s, 16'h301);
        end
        Out_RDY = 1'b1;
        drain("t3");

        // Granted stream gaps for 3 cycles with rem=2 while others request.
        reset_dut();
        BURST_LEN = 16'd4;
        for (int s = 0; s < N; s++) load(s, 16'(16'h400 + (s << 4)), 4);
        for (int s = 0; s < N; s++)
            for (int k = 0; k < 4; k++) push(16'(16'h400 + (s << 4) + k));
        tick();
        tick();
        tick();
        src_en[0] = 1'b0;
        drive();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4_gap_grant", grant_s, 3'b001);
            check("t4_gap_ack", ack_s, 0);
        end
        src_en[0] = 1'b1;
        drive();
        drain("t4");

        // BURST_LEN=0 behaves as 1.
        reset_dut();
        BURST_LEN = 16'd0;
        load(0, 16'h500, 2);
        load(1, 16'h510, 2);
        push(16'h500); push(16'h510); push(16'h501); push(16'h511);
        tick();
        check("t5a_grant_c0", grant_s, 0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("t5a_grant", grant_s,
                  (k % 2 == 1) ? ((((k - 1) / 2) % 2 == 1) ? 3'b010 : 3'b001) : 3'b000);
        end
        drain("t5a");

        // On-the-fly change 4 -> 1: current burst stays 4, next uses 1.
        BURST_LEN = 16'd4;
        load(2, 16'h520, 5);
        for (int k = 0; k < 5; k++) push(16'(16'h520 + k));
        tick();
        check("t5b_grant_c0", grant_s, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) BURST_LEN = 16'd1;
            check("t5b_grant", grant_s, 3'b100);
            check("t5b_ack", ack_s, 3'b100);
        end
        tick();
        check("t5b_grant_c5", grant_s, 0);
        tick();
        check("t5b_grant_c6", grant_s, 3'b100);
        check("t5b_ack_c6", ack_s, 3'b100);
        tick();
        check("t5b_grant_c7", grant_s, 0);
        drain("t5b");

        // Reset in the cycle a token is accepted with the output register full.
        reset_dut();
        BURST_LEN = 16'd4;
        load(1, 16'h610, 4);
        push(16'h610);
        tick();
        tick();
        check("t6_grant_c1", grant_s, 3'b010);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        BURST_LEN = 16'd2;
        load(0, 16'h600, 2);
        push(16'h600); push(16'h601); push(16'h612); push(16'h613);
        tick();
        check("t6_rst_grant", grant_s, 0);
        check("t6_rst_ack", ack_s, 0);
        check("t6_rst_send", 32'(send_s), 0);
        check("t6_rst_busy", 32'(busy_s), 0);
        check("t6_rst_data", data_s, 0);
        check("t6_rst_count", cnt_s, 0);
        tick();
        check("t6_next_grant", grant_s, 3'b001);
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
